pic_sync_irq_ctrl: RTL
======================

// Module: pic_sync_irq_ctrl
// PURPOSE
//  Synchronous, parametrised successor of the 8259A-style interrupt controller.
//  Accepts NUM_IRQ request lines and latches them into IRR, applies a mask and fixed or rotating priority,
//  raises INT, and runs a two-pulse INTA handshake that returns an 8-bit vector.
//  Single clock domain; slots beside the CPU bus decoder in place of the asynchronous PIC.
// PARAMETERS
//  NUM_IRQ   8      number of request lines, legal range 2..16
//  ID_W      4      width of the interrupt ID; must be >= clog2(NUM_IRQ)
//  LEVEL_DEF 0      IRR mode after reset: 0 = edge-triggered, 1 = level-triggered
// PORTS
//  CLK      in   1        clock; all logic is on the rising edge
//  RST_n    in   1        synchronous reset, active low
//  CS_n     in   1        chip select, active low
//  WR_n     in   1        write strobe, active low, sampled while CS_n=0
//  RD_n     in   1        read strobe, active low, sampled while CS_n=0
//  A        in   2        register address
//  DIN      in   16       write data
//  DOUT     out  16       read data, registered
//  IR       in   NUM_IRQ  interrupt request lines, already synchronous to CLK
//  INTA_n   in   1        interrupt acknowledge, active low, synchronous to CLK
//  INT      out  1        interrupt request to the CPU
//  VEC      out  8        vector output, valid while VEC_VLD=1
//  VEC_VLD  out  1        vector valid
// BEHAVIOUR
//  Reset (RST_n=0 at a CLK edge): IRR=0, ISR=0, MASK=all 1s, BASE=8'h08, CFG={LEVEL_DEF,AEOI=0}, PRIO_PTR=0,
//    FSM=IDLE, INT=0, VEC=0, VEC_VLD=0, DOUT=0.
//  Register write: occurs on a cycle with CS_n=0 and WR_n=0; a write strobe held for N cycles rewrites the register N times.
//    A=0 CFG[1:0]={AEOI,LEVEL}; A=1 MASK[NUM_IRQ-1:0]; A=2 BASE[7:0];
//    A=3 CMD: DIN[15]=non-specific EOI, DIN[14]=specific EOI with ID=DIN[ID_W-1:0]. Both set -> specific EOI wins.
//  Register read: on a cycle with CS_n=0 and RD_n=0, DOUT<=reg[A] on the next edge.
//    A=0 CFG, A=1 MASK, A=2 IRR, A=3 ISR. Unused upper bits read 0.
//  IRR, edge mode: a bit sets on a 0->1 transition of IR (previous-cycle sample kept in a register).
//    The bit clears when its ID is acknowledged.
//  IRR, level mode: IRR = IR & ~ISR; a request that drops before ACK1 is lost.
//  Priority: the lowest index has the highest priority, rotated so that index PRIO_PTR is the highest.
//    The candidate is the highest-priority bit of IRR & ~MASK that outranks every set ISR bit (nesting).
//  FSM:
//    IDLE: candidate exists -> PEND with INT=1 (1-cycle latency from the IRR bit setting).
//    PEND: INTA_n falling edge (sampled 1->0) -> ACK1: freeze the ID, set ISR[ID], clear IRR[ID].
//      If the candidate vanishes before ACK1 (mask written, level dropped) -> IDLE, INT=0.
//    ACK1: INT=0; the second INTA_n falling edge -> ACK2.
//    ACK2: VEC=BASE+ID (8-bit, wraps modulo 256), VEC_VLD=1 for exactly one cycle.
//      If AEOI=1, clear ISR[ID] in the same cycle. Next state IDLE.
//  EOI: non-specific EOI clears the highest-priority set ISR bit; specific EOI clears ISR[ID].
//    EOI with ISR=0 has no effect.
//  Simultaneous events: an EOI write and an ACK1 in the same cycle both take effect, ACK1 set applied after EOI clear.
//    An IR edge on the bit being acknowledged re-sets IRR next cycle.
//  MASK does not affect ISR or IRR contents, only candidate selection.
//  Reset asserted mid-handshake returns to IDLE with all state at reset values; a pending VEC is discarded.
// CONFIGURATION
//  ROTATE_EN defined: every EOI that clears bit k also sets PRIO_PTR=(k+1) mod NUM_IRQ (automatic rotation).
//    CMD DIN[13]=1 with DIN[ID_W-1:0] sets PRIO_PTR directly.
//  ROTATE_EN undefined: PRIO_PTR is tied to 0 (fixed priority); DIN[13] is ignored.
// TESTING
//  Reset, then MASK=0, BASE=8'h20, edge IR[3] pulse, two INTA pulses -> INT=1 then 0, VEC=8'h23 with VEC_VLD for 1 cycle, ISR=8'h08.
//  IR[5] and IR[2] rise together -> ID 2 served first; IR[5] is served only after the EOI and a new handshake; VEC=BASE+5.
//  ISR[4] set with no EOI, IR[6] rises -> INT stays 0; IR[1] rises -> INT=1 (nesting); non-specific EOI clears ISR[1] before ISR[4].
//  Level mode, IR[0] held then dropped before the first INTA -> FSM returns to IDLE, INT=0, IRR=0.
//  AEOI=1, one full handshake on IR[7] -> ISR=0 in the cycle after VEC_VLD; BASE=8'hFC with ID 7 -> VEC=8'h03 (wrap).
//  ROTATE_EN: EOI on ID 3, then IR[2] and IR[4] rise together -> ID 4 served first; RST_n low during ACK1 -> INT=0, VEC_VLD never asserts.

Source files
------------

// File: rtl/pic_sync_irq_ctrl.sv
// Synchronous 8259A-style interrupt controller: IRR/ISR/MASK, nested rotating priority, two-pulse INTA vector handshake.
// Define ROTATE_EN to enable automatic EOI rotation and direct PRIO_PTR writes; otherwise priority is fixed.
module pic_sync_irq_ctrl #(
  parameter int unsigned NUM_IRQ   = 8,
  parameter int unsigned ID_W      = 4,
  parameter bit          LEVEL_DEF = 1'b0
) (
  input  logic               CLK,
  input  logic               RST_n,
  input  logic               CS_n,
  input  logic               WR_n,
  input  logic               RD_n,
  input  logic [1:0]         A,
  input  logic [15:0]        DIN,
  output logic [15:0]        DOUT,
  input  logic [NUM_IRQ-1:0] IR,
  input  logic               INTA_n,
  output logic               INT,
  output logic [7:0]         VEC,
  output logic               VEC_VLD
);

  typedef enum logic [1:0] {IDLE, PEND, ACK1, ACK2} state_t;

  state_t             state;
  logic [NUM_IRQ-1:0] irr, isr, mask, ir_q;
  logic [7:0]         base;
  logic               cfg_level, cfg_aeoi, inta_q;
  logic [ID_W-1:0]    id_q, prio_ptr;

  logic               wr, rd, inta_fall, ack1, ack2;
  logic               cand_vld, blocked, top_vld, eoi_vld;
  logic [ID_W-1:0]    cand_id, top_id, eoi_id, din_id;
  logic [NUM_IRQ-1:0] rot_req, rot_isr, eoi_clr, ack_set, aeoi_clr, isr_nxt, irr_nxt;
  logic [15:0]        rd_data;
  logic               unused_din;

  function automatic logic [NUM_IRQ-1:0] rotate(input logic [NUM_IRQ-1:0] v, input logic [ID_W-1:0] p);
    logic [2*NUM_IRQ-1:0] d;
    d = {v, v} >> p;
    return d[NUM_IRQ-1:0];
  endfunction

  function automatic logic [NUM_IRQ-1:0] onehot(input logic [ID_W-1:0] id);
    logic [NUM_IRQ-1:0] oh;
    oh = '0;
    for (int k = 0; k < int'(NUM_IRQ); k++)
      if (ID_W'(k) == id) oh[k] = 1'b1;
    return oh;
  endfunction

  function automatic logic [ID_W-1:0] unrot(input int i, input logic [ID_W-1:0] p);
    return ID_W'((i + int'(p)) % int'(NUM_IRQ));
  endfunction

  assign unused_din = ^DIN;

  // Priority scan in rotated order; a set ISR bit blocks everything at or below it.
  always_comb begin
    wr        = !CS_n && !WR_n;
    rd        = !CS_n && !RD_n;
    inta_fall = inta_q && !INTA_n;
    din_id    = DIN[ID_W-1:0];
    rot_req   = rotate(irr & ~mask, prio_ptr);
    rot_isr   = rotate(isr, prio_ptr);
    cand_vld  = 1'b0;
    cand_id   = '0;
    blocked   = 1'b0;
    top_vld   = 1'b0;
    top_id    = '0;
    for (int i = 0; i < int'(NUM_IRQ); i++) begin
      if (!cand_vld && !blocked) begin
        if (rot_isr[i]) begin
          blocked = 1'b1;
        end else if (rot_req[i]) begin
          cand_vld = 1'b1;
          cand_id  = unrot(i, prio_ptr);
        end
      end
      if (!top_vld && rot_isr[i]) begin
        top_vld = 1'b1;
        top_id  = unrot(i, prio_ptr);
      end
    end

    eoi_clr = '0;
    eoi_id  = '0;
    if (wr && A == 2'd3) begin
      if (DIN[14]) begin
        eoi_id  = din_id;
        eoi_clr = onehot(din_id) & isr;
      end else if (DIN[15]) begin
        eoi_id  = top_id;
        eoi_clr = top_vld ? onehot(top_id) : '0;
      end
    end
    eoi_vld  = |eoi_clr;

    ack1     = (state == PEND) && inta_fall && cand_vld;
    ack2     = (state == ACK1) && inta_fall;
    ack_set  = ack1 ? onehot(cand_id) : '0;
    aeoi_clr = (ack2 && cfg_aeoi) ? (onehot(id_q) & isr) : '0;
    isr_nxt  = ((isr & ~eoi_clr) | ack_set) & ~aeoi_clr;
    irr_nxt  = cfg_level ? (IR & ~isr_nxt) : ((irr & ~ack_set) | (IR & ~ir_q));

    case (A)
      2'd0:    rd_data = 16'({cfg_aeoi, cfg_level});
      2'd1:    rd_data = 16'(mask);
      2'd2:    rd_data = 16'(irr);
      default: rd_data = 16'(isr);
    endcase
  end

`ifdef ROTATE_EN
  logic [ID_W-1:0] ptr_nxt;

  always_comb begin
    ptr_nxt = prio_ptr;
    if (eoi_vld)                     ptr_nxt = unrot(1, eoi_id);
    if (|aeoi_clr)                   ptr_nxt = unrot(1, id_q);
    if (wr && A == 2'd3 && DIN[13])  ptr_nxt = unrot(0, din_id);
  end

  always_ff @(posedge CLK) begin
    if (!RST_n) prio_ptr <= '0;
    else        prio_ptr <= ptr_nxt;
  end
`else
  assign prio_ptr = '0;
`endif

  // Registers, bus interface and INTA handshake FSM.
  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      state     <= IDLE;
      irr       <= '0;
      isr       <= '0;
      mask      <= '1;
      ir_q      <= '0;
      base      <= 8'h08;
      cfg_level <= LEVEL_DEF;
      cfg_aeoi  <= 1'b0;
      inta_q    <= 1'b1;
      id_q      <= '0;
      INT       <= 1'b0;
      VEC       <= 8'h00;
      VEC_VLD   <= 1'b0;
      DOUT      <= 16'h0000;
    end else begin
      ir_q    <= IR;
      inta_q  <= INTA_n;
      irr     <= irr_nxt;
      isr     <= isr_nxt;
      VEC_VLD <= 1'b0;
      if (wr) begin
        case (A)
          2'd0:    {cfg_aeoi, cfg_level} <= DIN[1:0];
          2'd1:    mask <= DIN[NUM_IRQ-1:0];
          2'd2:    base <= DIN[7:0];
          default: ;
        endcase
      end
      if (rd) DOUT <= rd_data;
      case (state)
        IDLE: begin
          if (cand_vld) begin
            state <= PEND;
            INT   <= 1'b1;
          end
        end
        PEND: begin
          if (!cand_vld) begin
            state <= IDLE;
            INT   <= 1'b0;
          end else if (inta_fall) begin
            state <= ACK1;
            INT   <= 1'b0;
            id_q  <= cand_id;
          end
        end
        ACK1: begin
          if (inta_fall) begin
            state   <= ACK2;
            VEC     <= base + 8'(id_q);
            VEC_VLD <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
